// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ masters, with an
// in-order return FIFO that routes responses back. Optional counters: MEM_ARB_STATS_EN.
module mem_rr_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               s_mem_req,
    output logic [NUM_REQ-1:0]               s_mem_gnt,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_mem_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_mem_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  s_mem_be,
    input  logic [NUM_REQ-1:0]               s_mem_we,
    output logic [NUM_REQ-1:0]               s_mem_rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    s_mem_rdata,
    output logic                             m_mem_req,
    input  logic                             m_mem_gnt,
    output logic [ADDR_WIDTH-1:0]            m_mem_addr,
    output logic [DATA_WIDTH-1:0]            m_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_mem_be,
    output logic                             m_mem_we,
    input  logic                             m_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            m_mem_rdata,
    output logic                             err_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]            grant_cnt_o,
    output logic [31:0]                      full_stall_cnt_o
`endif
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;
    localparam logic [IDX_W:0]   NUM_REQ_E  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);

    genvar gi;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   fifo_mem [MAX_OUTSTANDING];

    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   rr_off, rr_sel, sel, fifo_head;
    logic [IDX_W:0]     rr_sum;
    logic               fifo_full, fifo_empty, handshake, push, pop;

    // Rotate the request vector so rr_ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        req_rot = {s_mem_req, s_mem_req} >> rr_ptr_q;
        rr_off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_off = IDX_W'(i);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (rr_sum >= NUM_REQ_E) rr_sum = rr_sum - NUM_REQ_E;
        rr_sel = rr_sum[IDX_W-1:0];
    end

    assign sel        = lock_q ? lock_idx_q : rr_sel;
    assign fifo_full  = (count_q == FIFO_DEPTH);
    assign fifo_empty = (count_q == '0);
    assign m_mem_req  = (|s_mem_req) & ~fifo_full;
    assign handshake  = m_mem_req & m_mem_gnt;
    assign push       = handshake;
    assign pop        = m_mem_rvalid & ~fifo_empty;
    assign fifo_head  = fifo_mem[rd_ptr_q];

    assign m_mem_addr  = s_mem_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_mem_wdata = s_mem_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
    assign m_mem_be    = s_mem_be[sel*BE_WIDTH +: BE_WIDTH];
    assign m_mem_we    = s_mem_we[sel];
    assign err_o       = err_q;

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign s_mem_gnt[gi]    = handshake & (sel == IDX_W'(gi));
        assign s_mem_rvalid[gi] = pop & (fifo_head == IDX_W'(gi));
        assign s_mem_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_mem_rdata;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
            lock_d   = 1'b0;
        end else if (m_mem_req) begin
            // Memory stalled: freeze the selection so the payload cannot change under it.
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q | (m_mem_rvalid & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= sel;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] full_stall_cnt_q, full_stall_cnt_d;

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        logic [31:0] grant_cnt_q, grant_cnt_d;

        always_comb grant_cnt_d = grant_cnt_q + 32'(s_mem_gnt[gi]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) grant_cnt_q <= '0;
            else         grant_cnt_q <= grant_cnt_d;
        end

        assign grant_cnt_o[gi*32 +: 32] = grant_cnt_q;
    end

    always_comb full_stall_cnt_d = full_stall_cnt_q + 32'((|s_mem_req) & fifo_full);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) full_stall_cnt_q <= '0;
        else         full_stall_cnt_q <= full_stall_cnt_d;
    end

    assign full_stall_cnt_o = full_stall_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_mem_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      s_mem_req = '0;
    logic [N-1:0]      s_mem_gnt;
    logic [N*AW-1:0]   s_mem_addr = '0;
    logic [N*DW-1:0]   s_mem_wdata = '0;
    logic [N*BW-1:0]   s_mem_be = '0;
    logic [N-1:0]      s_mem_we = '0;
    logic [N-1:0]      s_mem_rvalid;
    logic [N*DW-1:0]   s_mem_rdata;
    logic              m_mem_req;
    logic              m_mem_gnt = 1'b0;
    logic [AW-1:0]     m_mem_addr;
    logic [DW-1:0]     m_mem_wdata;
    logic [BW-1:0]     m_mem_be;
    logic              m_mem_we;
    logic              m_mem_rvalid = 1'b0;
    logic [DW-1:0]     m_mem_rdata = '0;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    mem_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt),
        .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
        .s_mem_be(s_mem_be), .s_mem_we(s_mem_we),
        .s_mem_rvalid(s_mem_rvalid), .s_mem_rdata(s_mem_rdata),
        .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt),
        .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata),
        .m_mem_be(m_mem_be), .m_mem_we(m_mem_we),
        .m_mem_rvalid(m_mem_rvalid), .m_mem_rdata(m_mem_rdata),
        .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_rr, m_lock, m_lock_idx, m_sel;
    int m_q[$];
    bit m_err, m_hs;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [BW-1:0] be_a    [N];
    logic          we_a    [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            s_mem_addr[i*AW +: AW]  = addr_a[i];
            s_mem_wdata[i*DW +: DW] = wdata_a[i];
            s_mem_be[i*BW +: BW]    = be_a[i];
            s_mem_we[i]             = we_a[i];
        end
    endtask

    function automatic int exp_sel();
        if (m_lock != 0) return m_lock_idx;
        for (int k = 0; k < N; k++) begin
            int idx = (m_rr + k) % N;
            if (s_mem_req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit exp_mreq();
        return (s_mem_req != '0) && (m_q.size() < MO);
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g = '0;
        if (exp_mreq() && m_mem_gnt) g[exp_sel()] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] exp_rvalid();
        logic [N-1:0] v = '0;
        if (m_mem_rvalid && m_q.size() > 0) v[m_q[0]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 1'b0;
        m_q.delete();
    endtask

    // Advance one clock and update the model from the inputs present at the edge.
    task automatic tick();
        int s;
        bit mreq;
        @(posedge clk_i);
        s    = exp_sel();
        mreq = exp_mreq();
        m_hs = mreq && m_mem_gnt;
        m_sel = s;
        if (m_mem_rvalid) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                $display("[%0t] response -> req%0d data=%h", $time, m_q[0], m_mem_rdata);
                void'(m_q.pop_front());
            end
        end
        if (m_hs) begin
            $display("[%0t] grant  -> req%0d addr=%h", $time, s, addr_a[s]);
            m_q.push_back(s);
            m_rr   = (s + 1) % N;
            m_lock = 0;
        end else if (mreq) begin
            m_lock     = 1;
            m_lock_idx = s;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        s_mem_req = '0; m_mem_gnt = 1'b0; m_mem_rvalid = 1'b0; m_mem_rdata = '0;
        #7;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        s_mem_req = '0; m_mem_gnt = 1'b0; m_mem_rvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 32'h1000 * (i + 1); wdata_a[i] = '0; be_a[i] = '1; we_a[i] = 1'b0;
        end
        apply();
        #3;
        n_checks++; if (s_mem_gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", s_mem_gnt); end
        n_checks++; if (s_mem_rvalid !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", s_mem_rvalid); end
        n_checks++; if (m_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got=%b exp=0", m_mem_req); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_fairness();
        logic [N-1:0] eg;
        s_mem_req = 2'b11; m_mem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_mem_rvalid = (i > 0);
            m_mem_rdata  = $urandom;
            apply();
            #2;
            eg = N'(1) << (i % 2);
            n_checks++; if (s_mem_gnt !== eg) begin n_fail++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%b", i, s_mem_gnt, eg); end
            n_checks++; if (m_mem_addr !== addr_a[i % 2]) begin n_fail++; $display("FAIL fair_addr cyc=%0d got=%h exp=%h", i, m_mem_addr, addr_a[i % 2]); end
            if (i > 0) begin
                eg = N'(1) << ((i - 1) % 2);
                n_checks++; if (s_mem_rvalid !== eg) begin n_fail++; $display("FAIL fair_rvalid cyc=%0d got=%b exp=%b", i, s_mem_rvalid, eg); end
            end
            tick();
        end
        s_mem_req = '0; m_mem_rvalid = 1'b0;
    endtask

    task automatic test_lock();
        logic [N-1:0] req_tab [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
        logic         gnt_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [N-1:0] eg_tab  [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        int           ea_tab  [5] = '{1, 1, 1, 1, 0};
        do_reset();
        addr_a[0] = $urandom; addr_a[1] = addr_a[0] + 32'h100;
        apply();
        for (int c = 0; c < 5; c++) begin
            s_mem_req = req_tab[c]; m_mem_gnt = gnt_tab[c];
            #2;
            n_checks++; if (m_mem_addr !== addr_a[ea_tab[c]]) begin n_fail++; $display("FAIL lock_addr cyc=%0d got=%h exp=%h", c, m_mem_addr, addr_a[ea_tab[c]]); end
            n_checks++; if (s_mem_gnt !== eg_tab[c]) begin n_fail++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", c, s_mem_gnt, eg_tab[c]); end
            n_checks++; if (m_mem_req !== 1'b1) begin n_fail++; $display("FAIL lock_mreq cyc=%0d got=%b exp=1", c, m_mem_req); end
            tick();
        end
        s_mem_req = '0; m_mem_gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        int grants;
        do_reset();
        s_mem_req = 2'b11; m_mem_gnt = 1'b1; m_mem_rvalid = 1'b0;
        grants = 0;
        for (int c = 0; c < 7; c++) begin
            #2;
            grants += $countones(s_mem_gnt);
            if (c >= 4) begin
                n_checks++; if (m_mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_mreq_full cyc=%0d got=%b exp=0", c, m_mem_req); end
            end
            tick();
        end
        n_checks++; if (grants != MO) begin n_fail++; $display("FAIL bp_grants got=%0d exp=%0d", grants, MO); end
        m_mem_rvalid = 1'b1; m_mem_rdata = $urandom;
        #2;
        n_checks++; if (s_mem_gnt !== '0) begin n_fail++; $display("FAIL bp_gnt_on_pop got=%b exp=00", s_mem_gnt); end
        tick();
        m_mem_rvalid = 1'b0;
        grants = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            grants += $countones(s_mem_gnt);
            tick();
        end
        n_checks++; if (grants != 1) begin n_fail++; $display("FAIL bp_after_pop got=%0d exp=1", grants); end
        s_mem_req = '0;
    endtask

    task automatic test_routing();
        logic [N-1:0] ord [3] = '{2'b10, 2'b01, 2'b10};
        logic [DW-1:0] d [3];
        do_reset();
        m_mem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_mem_req = ord[k];
            #2;
            n_checks++; if (s_mem_gnt !== ord[k]) begin n_fail++; $display("FAIL route_gnt k=%0d got=%b exp=%b", k, s_mem_gnt, ord[k]); end
            tick();
        end
        s_mem_req = '0; m_mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d[k] = $urandom;
            m_mem_rvalid = 1'b1; m_mem_rdata = d[k];
            #2;
            n_checks++; if (s_mem_rvalid !== ord[k]) begin n_fail++; $display("FAIL route_rvalid k=%0d got=%b exp=%b", k, s_mem_rvalid, ord[k]); end
            n_checks++; if (s_mem_rdata[DW-1:0] !== d[k] || s_mem_rdata[2*DW-1:DW] !== d[k]) begin n_fail++; $display("FAIL route_rdata k=%0d got=%h exp=%h", k, s_mem_rdata, d[k]); end
            tick();
        end
        m_mem_rvalid = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [N-1:0] exp_rv [3] = '{2'b01, 2'b10, 2'b00};
        do_reset();
        m_mem_gnt = 1'b1;
        s_mem_req = 2'b10; tick();
        s_mem_req = 2'b01; tick();
        s_mem_req = 2'b10; m_mem_rvalid = 1'b1; m_mem_rdata = $urandom;
        #2;
        n_checks++; if (s_mem_gnt !== 2'b10) begin n_fail++; $display("FAIL pp_gnt got=%b exp=10", s_mem_gnt); end
        n_checks++; if (s_mem_rvalid !== 2'b10) begin n_fail++; $display("FAIL pp_rvalid got=%b exp=10", s_mem_rvalid); end
        tick();
        s_mem_req = '0; m_mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_mem_rdata = $urandom;
            #2;
            n_checks++; if (s_mem_rvalid !== exp_rv[k]) begin n_fail++; $display("FAIL pp_drain k=%0d got=%b exp=%b", k, s_mem_rvalid, exp_rv[k]); end
            n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL pp_err_early k=%0d got=%b exp=0", k, err_o); end
            tick();
        end
        m_mem_rvalid = 1'b0;
        #2;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL pp_err_after got=%b exp=1", err_o); end
    endtask

    task automatic test_spurious_reset();
        do_reset();
        m_mem_rvalid = 1'b1; m_mem_rdata = $urandom;
        #2;
        n_checks++; if (s_mem_rvalid !== '0) begin n_fail++; $display("FAIL spur_rvalid got=%b exp=00", s_mem_rvalid); end
        tick();
        m_mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL spur_err k=%0d got=%b exp=1", k, err_o); end
            tick();
        end
        s_mem_req = 2'b11; m_mem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        s_mem_req = '0; m_mem_gnt = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_o); end
        n_checks++; if (m_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mreq got=%b exp=0", m_mem_req); end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m_mem_rvalid = 1'b1;
        #2;
        n_checks++; if (s_mem_rvalid !== '0) begin n_fail++; $display("FAIL rst_fifo_empty got=%b exp=00", s_mem_rvalid); end
        tick();
        m_mem_rvalid = 1'b0;
        s_mem_req = 2'b11; m_mem_gnt = 1'b1;
        #2;
        n_checks++; if (s_mem_gnt !== 2'b01) begin n_fail++; $display("FAIL rst_rr_ptr got=%b exp=01", s_mem_gnt); end
        tick();
        s_mem_req = '0; m_mem_gnt = 1'b0;
    endtask

    task automatic test_random();
        bit pend [N];
        logic [N-1:0] eg, erv;
        int s;
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pend[i]    = 1'($urandom_range(0, 1));
                    addr_a[i]  = $urandom;
                    wdata_a[i] = $urandom;
                    be_a[i]    = BW'($urandom);
                    we_a[i]    = 1'($urandom_range(0, 1));
                end
                s_mem_req[i] = pend[i];
            end
            apply();
            m_mem_gnt    = ($urandom_range(0, 3) != 0);
            m_mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            m_mem_rdata  = $urandom;
            #2;
            eg  = exp_gnt();
            erv = exp_rvalid();
            s   = exp_sel();
            n_checks++; if (m_mem_req !== exp_mreq()) begin n_fail++; $display("FAIL rand_mreq cyc=%0d got=%b exp=%b", c, m_mem_req, exp_mreq()); end
            n_checks++; if (s_mem_gnt !== eg) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, s_mem_gnt, eg); end
            n_checks++; if (s_mem_rvalid !== erv) begin n_fail++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", c, s_mem_rvalid, erv); end
            n_checks++; if (err_o !== m_err) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err_o, m_err); end
            if (exp_mreq()) begin
                n_checks++;
                if (m_mem_addr !== addr_a[s] || m_mem_wdata !== wdata_a[s] ||
                    m_mem_be !== be_a[s] || m_mem_we !== we_a[s]) begin
                    n_fail++;
                    $display("FAIL rand_payload cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", c,
                             m_mem_addr, m_mem_wdata, m_mem_be, m_mem_we,
                             addr_a[s], wdata_a[s], be_a[s], we_a[s]);
                end
            end
            tick();
            if (m_hs) pend[m_sel] = 1'b0;
        end
        s_mem_req = '0; m_mem_gnt = 1'b0; m_mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_routing();
        test_push_pop();
        test_spurious_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares one memory port among `NUM_REQ` memory-protocol masters, e.g. several `axi_to_mem` bridges feeding a single SRAM bank. Requests are forwarded one per cycle. The arbiter records the granted requester for each accepted request in an in-order return FIFO, and uses it to route each `mem_rvalid`/`mem_rdata` back to the requester that issued the request. It sits between the bridges' memory master ports and the memory's slave port.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..8)
- `ADDR_WIDTH`, 32, memory address width
- `DATA_WIDTH`, 32, memory data width; byte-enable width is `DATA_WIDTH/8`
- `MAX_OUTSTANDING`, 4, return-FIFO depth (power of two, ≥2)

Ports (`s_*` vectors are indexed per requester):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low
- `s_mem_req`  in  NUM_REQ  request per requester
- `s_mem_gnt`  out  NUM_REQ  grant per requester
- `s_mem_addr`  in  NUM_REQ×ADDR_WIDTH  addresses
- `s_mem_wdata`  in  NUM_REQ×DATA_WIDTH  write data
- `s_mem_be`  in  NUM_REQ×DATA_WIDTH/8  byte enables
- `s_mem_we`  in  NUM_REQ  write enables
- `s_mem_rvalid`  out  NUM_REQ  response valid per requester
- `s_mem_rdata`  out  NUM_REQ×DATA_WIDTH  response data (broadcast)
- `m_mem_req`  out  1  request to memory
- `m_mem_gnt`  in  1  grant from memory
- `m_mem_addr`  out  ADDR_WIDTH  forwarded address
- `m_mem_wdata`  out  DATA_WIDTH  forwarded write data
- `m_mem_be`  out  DATA_WIDTH/8  forwarded byte enables
- `m_mem_we`  out  1  forwarded write enable
- `m_mem_rvalid`  in  1  response valid; responses are in order, one per granted request
- `m_mem_rdata`  in  DATA_WIDTH  response data
- `err_o`  out  1  sticky flag: `m_mem_rvalid` seen with the return FIFO empty

## Operation
- **Selection:**
  - The selected index `sel` is the first requester with `s_mem_req` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - If `lock_q` is set, `sel = lock_idx_q` instead.
- **Forwarding:**
  - `m_mem_req = |s_mem_req & !fifo_full`.
  - `m_mem_addr/wdata/be/we` are muxed from `sel`.
- **Grant:**
  - `s_mem_gnt[sel] = m_mem_req & m_mem_gnt`; all other grants are 0.
  - Handshake = `m_mem_req & m_mem_gnt`.
- **Lock:**
  - When `m_mem_req` is high and `m_mem_gnt` is low, set `lock_q` and store `lock_idx_q = sel`.
  - Clear `lock_q` on the handshake.
  - This keeps the forwarded payload stable until the memory grants it. Requesters must hold `req` and payload until granted.
- **Pointer:** on handshake, `rr_ptr <= (sel+1) mod NUM_REQ`. On any other cycle it is unchanged.
- **Return FIFO:**
  - Push `sel` on handshake; pop on `m_mem_rvalid`.
  - Push and pop in the same cycle are both allowed, and the count is unchanged.
  - `fifo_full` is evaluated on the registered count. No grant is issued while full, even if a pop occurs in that cycle.
- **Response routing:**
  - `s_mem_rvalid[fifo_head] = m_mem_rvalid` when the FIFO is not empty.
  - `s_mem_rdata = m_mem_rdata` to all requesters.
- **Spurious response:** `m_mem_rvalid` with the FIFO empty is dropped, and `err_o` is set. It stays set until reset.
- **Reset:** resetting mid-operation discards outstanding entries. No recovery of in-flight responses.

## Timing
- Reset values:
  - `rr_ptr=0`, `lock_q=0`, FIFO empty, `err_o=0`.
  - All `s_mem_gnt`/`s_mem_rvalid` are 0.
  - `m_mem_req` is 0 while all `s_mem_req` are 0.
- Request path is combinational: zero-cycle `s_mem_req`→`m_mem_req`, and zero-cycle `m_mem_gnt`→`s_mem_gnt`.
- Response path is combinational: zero-cycle `m_mem_rvalid`→`s_mem_rvalid`.
- Throughput is one grant per cycle while the FIFO is not full.
- The return FIFO adds no response latency.
- At most `MAX_OUTSTANDING` requests are granted but not yet responded to.
- A newly asserted request cannot preempt a locked, stalled selection.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds output `grant_cnt_o` (NUM_REQ×32): per-requester handshake counters.
  - Adds output `full_stall_cnt_o` (32): counts cycles with `|s_mem_req & fifo_full`.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- **Fairness:** NUM_REQ=2, both requesting continuously, `m_mem_gnt`=1 → grants alternate 0,1,0,1 starting with 0 after reset.
- **Lock:**
  - Stimulus: requester 1 requests with `m_mem_gnt`=0 for 3 cycles; requester 0 asserts `req` in cycle 2.
  - Required: `m_mem_addr` stays at requester 1's address; the first grant goes to 1, then 0.
- **Backpressure:**
  - Stimulus: MAX_OUTSTANDING=4, no `m_mem_rvalid`, continuous requests.
  - Required: exactly 4 grants, then `m_mem_req`=0.
  - Required after one `rvalid`: exactly one further grant on a following cycle.
- **Routing:**
  - Stimulus: grant order 1,0,1, responses D1,D2,D3.
  - Required: `s_mem_rvalid` pulses on 1,0,1 in that order, with `s_mem_rdata`=D1,D2,D3.
- **Simultaneous push/pop:**
  - Stimulus: FIFO holds 2 entries; a handshake and an `rvalid` occur in the same cycle.
  - Required: count stays 2, and the head is routed correctly.
- **Spurious/reset:**
  - Stimulus: `m_mem_rvalid` with the FIFO empty.
  - Required: no `s_mem_rvalid`; `err_o`=1.
  - Stimulus: `rst_ni` pulsed low mid-burst.
  - Required: `err_o`=0, FIFO empty, `rr_ptr`=0.
